// File: rtl/ysyx_23060236_btb_assoc_pkg.sv
// Shared constants and types for the set-associative BTB: 2-bit direction
// counter encodings and the default address width.
package ysyx_23060236_btb_assoc_pkg;

    localparam int BTB_ADDR_LEN = 32;

    typedef logic [1:0] cnt_t;

    localparam cnt_t BTB_CNT_SNT = 2'd0;
    localparam cnt_t BTB_CNT_WNT = 2'd1;
    localparam cnt_t BTB_CNT_WT  = 2'd2;
    localparam cnt_t BTB_CNT_ST  = 2'd3;

    // Taken prediction is the counter's upper half (WT or ST).
    function automatic logic cnt_predicts_taken(input cnt_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/ysyx_23060236_btb_cnt2.sv
// 2-bit saturating direction counter: next value for a resolved outcome.
module ysyx_23060236_btb_cnt2
    import ysyx_23060236_btb_assoc_pkg::*;
(
    input  cnt_t value,
    input  logic taken,
    output cnt_t next_value
);

    always_comb begin
        next_value = value;
        if (taken) begin
            if (value != BTB_CNT_ST)
                next_value = value + 2'd1;
        end else if (value != BTB_CNT_SNT) begin
            next_value = value - 2'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060236_btb_assoc.sv
// Set-associative branch target buffer with per-entry 2-bit direction counters,
// round-robin replacement per set and a synchronous flush.
module ysyx_23060236_btb_assoc
    import ysyx_23060236_btb_assoc_pkg::*;
#(
    parameter int ADDR_LEN   = BTB_ADDR_LEN,
    parameter int OFFSET_LEN = 2,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] btb_araddr,
    output logic [ADDR_LEN-1:0] btb_rdata,
    output logic                btb_hit,
    output logic                btb_taken,
    input  logic                btb_wvalid,
    input  logic [ADDR_LEN-1:0] btb_awaddr,
    input  logic [ADDR_LEN-1:0] btb_wdata,
    input  logic                btb_wtaken,
    input  logic                btb_flush
);

    localparam int INDEX_LEN = $clog2(SETS);
    localparam int TAG_LEN   = ADDR_LEN - OFFSET_LEN - INDEX_LEN;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [SETS-1:0][WAYS-1:0]               valid;
    logic [SETS-1:0][WAYS-1:0][TAG_LEN-1:0]  tags;
    logic [SETS-1:0][WAYS-1:0][ADDR_LEN-1:0] targets;
    cnt_t [SETS-1:0][WAYS-1:0]               cnts;
    logic [SETS-1:0][WAY_W-1:0]              ptr;

    logic [INDEX_LEN-1:0] r_idx, w_idx;
    logic [TAG_LEN-1:0]   r_tag, w_tag;

    assign r_idx = btb_araddr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
    assign r_tag = btb_araddr[ADDR_LEN-1:OFFSET_LEN+INDEX_LEN];
    assign w_idx = btb_awaddr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
    assign w_tag = btb_awaddr[ADDR_LEN-1:OFFSET_LEN+INDEX_LEN];

    logic unused_awaddr_lo;
    assign unused_awaddr_lo = ^btb_awaddr[OFFSET_LEN-1:0];

    // Lookup side
    logic             r_hit;
    logic [WAY_W-1:0] r_way;

    always_comb begin
        r_hit = 1'b0;
        r_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[r_idx][w] && tags[r_idx][w] == r_tag) begin
                r_hit = 1'b1;
                r_way = WAY_W'(w);
            end
        end
    end

    assign btb_hit   = r_hit;
    assign btb_taken = r_hit && cnt_predicts_taken(cnts[r_idx][r_way]);
    assign btb_rdata = btb_taken ? targets[r_idx][r_way] : btb_araddr + ADDR_LEN'(4);

    // Update side: tag match and victim selection on the write set
    logic             w_hit;
    logic [WAY_W-1:0] w_way;
    logic             free_found;
    logic [WAY_W-1:0] victim;
    cnt_t             cnt_next;

    always_comb begin
        w_hit = 1'b0;
        w_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w_idx][w] && tags[w_idx][w] == w_tag) begin
                w_hit = 1'b1;
                w_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        free_found = 1'b0;
        victim     = (WAYS > 1) ? ptr[w_idx] : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w_idx][w]) begin
                free_found = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    ysyx_23060236_btb_cnt2 u_cnt2 (
        .value      (cnts[w_idx][w_way]),
        .taken      (btb_wtaken),
        .next_value (cnt_next)
    );

    logic do_update, do_alloc;
    assign do_update = btb_wvalid && !btb_flush && w_hit;
    assign do_alloc  = btb_wvalid && !btb_flush && !w_hit && btb_wtaken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            cnts  <= '0;
            ptr   <= '0;
        end else if (btb_flush) begin
            valid <= '0;
            ptr   <= '0;
        end else if (do_update) begin
            cnts[w_idx][w_way] <= cnt_next;
        end else if (do_alloc) begin
            valid[w_idx][victim] <= 1'b1;
            cnts[w_idx][victim]  <= BTB_CNT_WT;
            if (WAYS > 1 && !free_found)
                ptr[w_idx] <= WAY_W'(ptr[w_idx] + 1'b1);
        end
    end

    // Tags and targets need no reset; they are qualified by valid.
    always_ff @(posedge clock) begin
        if (do_update) begin
            targets[w_idx][w_way] <= btb_wdata;
        end else if (do_alloc) begin
            tags[w_idx][victim]    <= w_tag;
            targets[w_idx][victim] <= btb_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_btb_assoc.sv
// Directed bench for the set-associative BTB; expected lookups go through a scoreboard queue.
module tb_ysyx_23060236_btb_assoc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] btb_araddr = 32'h0;
    logic [31:0] btb_rdata;
    logic        btb_hit, btb_taken;
    logic        btb_wvalid = 1'b0;
    logic [31:0] btb_awaddr = 32'h0;
    logic [31:0] btb_wdata = 32'h0;
    logic        btb_wtaken = 1'b0;
    logic        btb_flush = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    ysyx_23060236_btb_assoc #(
        .ADDR_LEN(32), .OFFSET_LEN(2), .SETS(16), .WAYS(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btb_araddr (btb_araddr),
        .btb_rdata  (btb_rdata),
        .btb_hit    (btb_hit),
        .btb_taken  (btb_taken),
        .btb_wvalid (btb_wvalid),
        .btb_awaddr (btb_awaddr),
        .btb_wdata  (btb_wdata),
        .btb_wtaken (btb_wtaken),
        .btb_flush  (btb_flush)
    );

    always #5 clock = ~clock;

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert ({btb_hit, btb_taken, btb_rdata} === {e.hit, e.taken, e.rdata})
        else begin
            errors++;
            $error("FAIL %s: got hit=%b taken=%b rdata=%h, expected hit=%b taken=%b rdata=%h",
                   e.name, btb_hit, btb_taken, btb_rdata, e.hit, e.taken, e.rdata);
        end
    endtask

    // Lookup is combinational: drive, queue the expectation, let it settle, compare.
    task automatic look(input string nm, input logic [31:0] a,
                        input logic eh, input logic et, input logic [31:0] er);
        btb_araddr = a;
        sb.push_back('{nm, eh, et, er});
        #1;
        check_front();
    endtask

    task automatic hit_tk(input string nm, input logic [31:0] a, input logic [31:0] tgt);
        look(nm, a, 1'b1, 1'b1, tgt);
    endtask

    task automatic hit_nt(input string nm, input logic [31:0] a);
        look(nm, a, 1'b1, 1'b0, a + 32'd4);
    endtask

    task automatic miss(input string nm, input logic [31:0] a);
        look(nm, a, 1'b0, 1'b0, a + 32'd4);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic fl);
        @(negedge clock);
        btb_wvalid = 1'b1;
        btb_awaddr = pc;
        btb_wdata  = tgt;
        btb_wtaken = tk;
        btb_flush  = fl;
        @(posedge clock);
        #1;
        btb_wvalid = 1'b0;
        btb_flush  = 1'b0;
    endtask

    initial begin
        // Held in reset from time 0
        #2;
        miss("reset_lookup", 32'h8000_0000);
        @(negedge clock);
        reset = 1'b0;

        // Allocate and hit; same-cycle lookup sees the pre-update state
        @(negedge clock);
        btb_wvalid = 1'b1; btb_awaddr = 32'h8000_0010; btb_wdata = 32'h8000_0100; btb_wtaken = 1'b1;
        miss("same_cycle_alloc", 32'h8000_0010);
        @(posedge clock);
        #1;
        btb_wvalid = 1'b0;
        hit_tk("alloc_hit", 32'h8000_0010, 32'h8000_0100);
        miss("neighbour_miss", 32'h8000_0014);

        // Counter hysteresis: 2 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
        upd(32'h8000_0010, 32'h8000_0100, 1'b0, 1'b0);
        hit_nt("cnt_wnt", 32'h8000_0010);
        upd(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        hit_tk("cnt_wt", 32'h8000_0010, 32'h8000_0100);
        upd(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        upd(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        hit_tk("cnt_st_sat", 32'h8000_0010, 32'h8000_0100);
        upd(32'h8000_0010, 32'h8000_0100, 1'b0, 1'b0);
        hit_tk("cnt_st_to_wt", 32'h8000_0010, 32'h8000_0100);
        upd(32'h8000_0010, 32'h8000_0100, 1'b0, 1'b0);
        hit_nt("cnt_wt_to_wnt", 32'h8000_0010);

        // Saturation at 0: 1 -> 0 -> 0 -> 1 (still not taken)
        upd(32'h8000_0010, 32'h8000_0100, 1'b0, 1'b0);
        upd(32'h8000_0010, 32'h8000_0100, 1'b0, 1'b0);
        upd(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        hit_nt("cnt_snt_sat", 32'h8000_0010);

        // Hit overwrites target; counter 1 -> 2
        upd(32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0);
        hit_tk("target_overwrite", 32'h8000_0010, 32'h8000_0200);

        // Replacement in set 0
        upd(32'h8000_0000, 32'h8000_1000, 1'b1, 1'b0);
        upd(32'h8000_0040, 32'h8000_1040, 1'b1, 1'b0);
        hit_tk("fill_w0", 32'h8000_0000, 32'h8000_1000);
        hit_tk("fill_w1", 32'h8000_0040, 32'h8000_1040);
        upd(32'h8000_0080, 32'h8000_1080, 1'b1, 1'b0);
        miss("evict_w0", 32'h8000_0000);
        hit_tk("keep_w1", 32'h8000_0040, 32'h8000_1040);
        hit_tk("new_w0", 32'h8000_0080, 32'h8000_1080);
        upd(32'h8000_00C0, 32'h8000_10C0, 1'b1, 1'b0);
        miss("ptr1_evict_w1", 32'h8000_0040);
        hit_tk("ptr1_keep_w0", 32'h8000_0080, 32'h8000_1080);
        upd(32'h8000_0100, 32'h8000_1100, 1'b1, 1'b0);
        miss("ptr_wrap_evict_w0", 32'h8000_0080);
        hit_tk("ptr_wrap_keep_w1", 32'h8000_00C0, 32'h8000_10C0);
        hit_tk("other_set_intact", 32'h8000_0010, 32'h8000_0200);

        // Not-taken miss leaves no trace
        upd(32'h8000_0200, 32'h8000_2000, 1'b0, 1'b0);
        miss("nt_miss", 32'h8000_0200);

        // Asynchronous reset mid-run with entries present
        #2;
        reset = 1'b1;
        #1;
        miss("midrun_reset_0", 32'h8000_0000);
        miss("midrun_reset_10", 32'h8000_0010);
        @(negedge clock);
        reset = 1'b0;

        // Populate, fill set 0 with pointer at 1, then flush + update together
        upd(32'h8000_0010, 32'h8000_0300, 1'b1, 1'b0);
        upd(32'h8000_0020, 32'h8000_0320, 1'b1, 1'b0);
        upd(32'h8000_0000, 32'h8000_1000, 1'b1, 1'b0);
        upd(32'h8000_0040, 32'h8000_1040, 1'b1, 1'b0);
        upd(32'h8000_0080, 32'h8000_1080, 1'b1, 1'b0);
        hit_tk("pre_flush", 32'h8000_0020, 32'h8000_0320);
        upd(32'h8000_0400, 32'h8000_4000, 1'b1, 1'b1);
        miss("flush_10", 32'h8000_0010);
        miss("flush_20", 32'h8000_0020);
        miss("flush_40", 32'h8000_0040);
        miss("flush_80", 32'h8000_0080);
        miss("flush_drops_update", 32'h8000_0400);

        // Flush clears the pointer: third allocation again evicts way 0
        upd(32'h8000_0000, 32'h8000_5000, 1'b1, 1'b0);
        upd(32'h8000_0040, 32'h8000_5040, 1'b1, 1'b0);
        upd(32'h8000_0080, 32'h8000_5080, 1'b1, 1'b0);
        miss("flush_ptr_evict_w0", 32'h8000_0000);
        hit_tk("flush_ptr_keep_w1", 32'h8000_0040, 32'h8000_5040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
